// File: rtl/step_pulse_pkg.sv
// Shared types and helpers for the step/direction pulse generator.
// Holds the channel state encoding and the period/high-time clamp rules.
package step_pulse_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_HIGH  = 2'd2,
    ST_LOW   = 2'd3
  } step_state_e;

  localparam int unsigned MIN_PERIOD = 2;
  // Clamp helpers work at 32 bits; callers narrow the result to CNT_W (CNT_W <= 32).
  localparam int unsigned CLAMP_W    = 32;

  function automatic logic [CLAMP_W-1:0] clamp_period(input logic [CLAMP_W-1:0] period);
    return (period < CLAMP_W'(MIN_PERIOD)) ? CLAMP_W'(MIN_PERIOD) : period;
  endfunction

  // High time is at least one cycle and always leaves at least one low cycle.
  function automatic logic [CLAMP_W-1:0] clamp_high(input logic [CLAMP_W-1:0] high_len,
                                                    input logic [CLAMP_W-1:0] p);
    logic [CLAMP_W-1:0] h;
    h = (high_len == CLAMP_W'(0)) ? CLAMP_W'(1) : high_len;
    return (h > p - CLAMP_W'(1)) ? p - CLAMP_W'(1) : h;
  endfunction

endpackage

// File: rtl/step_pulse_gen_mc_chan.sv
// One step/dir channel: IDLE -> SETUP -> (HIGH -> LOW)* -> IDLE, with a phase
// counter for the timed states and a completed-pulse counter.
module step_pulse_chan
  import step_pulse_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int NUM_W     = 32,
  parameter int DIR_SETUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             dir_in,
  input  logic             invert,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] high_len,
  input  logic [NUM_W-1:0] pulse_num,
  output logic             step_out,
  output logic             dir_out,
  output logic             busy,
  output logic             done,
  output logic [NUM_W-1:0] pulse_cnt
);

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(DIR_SETUP - 1);

  step_state_e      state_r, state_s;
  logic [CNT_W-1:0] phase_r, phase_s;
  logic [CNT_W-1:0] p_r, p_s, h_r, h_s;
  logic [CNT_W-1:0] p_clamp_s, h_clamp_s, high_last_s, low_last_s;
  logic [NUM_W-1:0] num_r, num_s, cnt_r, cnt_s, cnt_inc_s;
  logic             inv_r, inv_s, dir_r, dir_s, pend_r, pend_s, done_s;
  logic             step_r, busy_r, done_r;

  assign p_clamp_s   = CNT_W'(clamp_period(CLAMP_W'(period)));
  assign h_clamp_s   = CNT_W'(clamp_high(CLAMP_W'(high_len), CLAMP_W'(p_clamp_s)));
  assign high_last_s = h_r - CNT_W'(1);
  assign low_last_s  = p_r - h_r - CNT_W'(1);
  assign cnt_inc_s   = cnt_r + NUM_W'(1);

  // Next-state, latched-parameter and counter logic for the channel FSM.
  always_comb begin
    state_s = state_r;
    phase_s = phase_r + CNT_W'(1);
    p_s     = p_r;
    h_s     = h_r;
    num_s   = num_r;
    inv_s   = inv_r;
    dir_s   = dir_r;
    pend_s  = pend_r;
    cnt_s   = cnt_r;
    done_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        phase_s = CNT_W'(0);
        pend_s  = 1'b0;
        if (start && !stop) begin
          p_s     = p_clamp_s;
          h_s     = h_clamp_s;
          num_s   = pulse_num;
          inv_s   = invert;
          dir_s   = dir_in;
          cnt_s   = NUM_W'(0);
          state_s = ST_SETUP;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (stop) begin
          state_s = ST_IDLE;
          phase_s = CNT_W'(0);
          done_s  = 1'b1;
        end else if (phase_r == SETUP_LAST) begin
          state_s = ST_HIGH;
          phase_s = CNT_W'(0);
        end else begin
          state_s = ST_SETUP;
        end
      end
      ST_HIGH: begin
        pend_s = pend_r | stop;
        if (phase_r == high_last_s) begin
          state_s = ST_LOW;
          phase_s = CNT_W'(0);
        end else begin
          state_s = ST_HIGH;
        end
      end
      ST_LOW: begin
        // A stop seen anywhere in the pulse lets that pulse finish and be counted.
        pend_s = pend_r | stop;
        if (phase_r == low_last_s) begin
          cnt_s   = cnt_inc_s;
          phase_s = CNT_W'(0);
          if (pend_s || ((num_r != NUM_W'(0)) && (cnt_inc_s == num_r))) begin
            state_s = ST_IDLE;
            done_s  = 1'b1;
          end else begin
            state_s = ST_HIGH;
          end
        end else begin
          state_s = ST_LOW;
        end
      end
      default: begin
        state_s = ST_IDLE;
        phase_s = CNT_W'(0);
      end
    endcase
  end

  // State, counters and registered outputs derived from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      phase_r <= CNT_W'(0);
      p_r     <= CNT_W'(0);
      h_r     <= CNT_W'(0);
      num_r   <= NUM_W'(0);
      cnt_r   <= NUM_W'(0);
      inv_r   <= 1'b0;
      dir_r   <= 1'b0;
      pend_r  <= 1'b0;
      step_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      phase_r <= phase_s;
      p_r     <= p_s;
      h_r     <= h_s;
      num_r   <= num_s;
      cnt_r   <= cnt_s;
      inv_r   <= inv_s;
      dir_r   <= dir_s;
      pend_r  <= pend_s;
      step_r  <= (state_s == ST_HIGH) ^ inv_s;
      busy_r  <= (state_s != ST_IDLE);
      done_r  <= done_s;
    end
  end

  assign step_out  = step_r;
  assign dir_out   = dir_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign pulse_cnt = cnt_r;

endmodule

// File: rtl/step_pulse_gen_mc.sv
// Multi-channel step/direction pulse generator: CHANNELS independent
// step_pulse_chan instances fed from flat, channel-sliced buses.
module step_pulse_gen_mc
  import step_pulse_pkg::*;
#(
  parameter int CHANNELS  = 2,
  parameter int CNT_W     = 16,
  parameter int NUM_W     = 32,
  parameter int DIR_SETUP = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       start,
  input  logic [CHANNELS-1:0]       stop,
  input  logic [CHANNELS-1:0]       dir_in,
  input  logic [CHANNELS-1:0]       invert,
  input  logic [CHANNELS*CNT_W-1:0] period,
  input  logic [CHANNELS*CNT_W-1:0] high_len,
  input  logic [CHANNELS*NUM_W-1:0] pulse_num,
  output logic [CHANNELS-1:0]       step_out,
  output logic [CHANNELS-1:0]       dir_out,
  output logic [CHANNELS-1:0]       busy,
  output logic [CHANNELS-1:0]       done,
  output logic [CHANNELS*NUM_W-1:0] pulse_cnt
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    step_pulse_chan #(
      .CNT_W    (CNT_W),
      .NUM_W    (NUM_W),
      .DIR_SETUP(DIR_SETUP)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .start    (start[i]),
      .stop     (stop[i]),
      .dir_in   (dir_in[i]),
      .invert   (invert[i]),
      .period   (period[i*CNT_W +: CNT_W]),
      .high_len (high_len[i*CNT_W +: CNT_W]),
      .pulse_num(pulse_num[i*NUM_W +: NUM_W]),
      .step_out (step_out[i]),
      .dir_out  (dir_out[i]),
      .busy     (busy[i]),
      .done     (done[i]),
      .pulse_cnt(pulse_cnt[i*NUM_W +: NUM_W])
    );
  end

endmodule

// File: tb/tb_step_pulse_gen_mc.sv
// Bench for step_pulse_gen_mc: table of single moves, hand-written handshake
// sequences, then random stimulus against a timeline-based reference model.
module tb_step_pulse_gen_mc;

  localparam int CH = 2;
  localparam int CW = 16;
  localparam int NW = 32;
  localparam int DS = 4;
  localparam longint NEVER = 64'sd1 << 60;

  logic               clk;
  logic               rst;
  logic [CH-1:0]      start, stop, dir_in, invert;
  logic [CH*CW-1:0]   period, high_len;
  logic [CH*NW-1:0]   pulse_num;
  logic [CH-1:0]      step_out, dir_out, busy, done;
  logic [CH*NW-1:0]   pulse_cnt;

  int checks = 0;
  int failures = 0;

  step_pulse_gen_mc #(.CHANNELS(CH), .CNT_W(CW), .NUM_W(NW), .DIR_SETUP(DS)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .dir_in(dir_in), .invert(invert),
    .period(period), .high_len(high_len), .pulse_num(pulse_num),
    .step_out(step_out), .dir_out(dir_out), .busy(busy), .done(done), .pulse_cnt(pulse_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Watch one channel after its start was driven; optionally pulse stop or a
  // second start at given offsets (offset 1 = first cycle after start sample).
  task automatic watch(input int ch, input int stop_at, input int restart_at,
                       output int done_off, output logic [NW-1:0] cnt_at, output int act_cycles);
    logic inv_l;
    inv_l = invert[ch];
    done_off = -1; cnt_at = '0; act_cycles = 0;
    for (int off = 1; off <= 300; off++) begin
      @(negedge clk);
      start[ch] = 1'b0; stop[ch] = 1'b0;
      if (step_out[ch] !== inv_l) act_cycles++;
      if (done[ch] === 1'b1) begin
        done_off = off; cnt_at = pulse_cnt[ch*NW +: NW];
        break;
      end
      if (off == stop_at) stop[ch] = 1'b1;
      if (off == restart_at) begin
        start[ch] = 1'b1; period[ch*CW +: CW] = 16'd9; pulse_num[ch*NW +: NW] = 32'd1;
      end
    end
  endtask

  task automatic load(input int ch, input int per, input int hl, input int num, input bit inv, input bit dir);
    period[ch*CW +: CW] = CW'(per);
    high_len[ch*CW +: CW] = CW'(hl);
    pulse_num[ch*NW +: NW] = NW'(num);
    invert[ch] = inv; dir_in[ch] = dir;
  endtask

  typedef struct {
    int per; int hl; int num; bit inv; bit dir;
    int exp_rise; int exp_high; int exp_gap; int exp_done; int exp_cnt;
  } vec_t;

  // Reference model: each move is a start time plus clamped P/H and an end pulse count.
  bit     m_has [CH];
  bit     m_inv [CH];
  bit     m_dir [CH];
  longint m_t0 [CH], m_p [CH], m_h [CH], m_nend [CH], m_tdone [CH];

  function automatic logic [NW+3:0] model_out(input int ch, input longint c);
    logic b, s, dn;
    logic [NW-1:0] cnt;
    longint o;
    if (!m_has[ch]) return {m_inv[ch], m_dir[ch], 1'b0, 1'b0, NW'(0)};
    o  = c - m_t0[ch] - 1;
    b  = (c < m_tdone[ch]);
    dn = (c == m_tdone[ch]);
    if (!b) cnt = NW'(m_nend[ch]);
    else if (o < DS) cnt = NW'(0);
    else cnt = NW'((o - DS) / m_p[ch]);
    s = m_inv[ch] ^ (b && (o >= DS) && (((o - DS) % m_p[ch]) < m_h[ch]));
    return {s, m_dir[ch], b, dn, cnt};
  endfunction

  initial begin
    vec_t vecs [6];
    int rise, rise2, hi, done_off, busy_bad, act_cycles, d0, d1, bad;
    logic [NW-1:0] cnt_at;
    bit act, prev;

    vecs[0] = '{10, 3, 4, 1'b0, 1'b1, 5, 3, 10, 45, 4};
    vecs[1] = '{ 1, 0, 3, 1'b0, 1'b0, 5, 1,  2, 11, 3};
    vecs[2] = '{ 5, 9, 2, 1'b1, 1'b1, 5, 4,  5, 15, 2};
    vecs[3] = '{ 7, 2, 2, 1'b1, 1'b0, 5, 2,  7, 19, 2};
    vecs[4] = '{ 3, 3, 5, 1'b0, 1'b1, 5, 2,  3, 20, 5};
    vecs[5] = '{ 0, 5, 2, 1'b1, 1'b1, 5, 1,  2,  9, 2};

    rst = 1'b1; start = '0; stop = '0; dir_in = '0; invert = '0;
    period = '0; high_len = '0; pulse_num = '0;
    repeat (3) @(negedge clk);
    check("reset_state", {step_out, dir_out, busy, done, pulse_cnt}, '0);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven single moves on channel 0; inputs scrambled mid-move.
    for (int v = 0; v < 6; v++) begin
      load(0, vecs[v].per, vecs[v].hl, vecs[v].num, vecs[v].inv, vecs[v].dir);
      start[0] = 1'b1;
      rise = -1; rise2 = -1; hi = 0; done_off = -1; busy_bad = 0; prev = 1'b0; cnt_at = '0;
      for (int off = 1; off <= 200; off++) begin
        @(negedge clk);
        start[0] = 1'b0;
        load(0, int'($urandom_range(0, 20)), int'($urandom_range(0, 20)), int'($urandom_range(0, 9)),
             1'($urandom), 1'($urandom));
        act = (step_out[0] !== vecs[v].inv);
        if (act && !prev) begin
          if (rise < 0) rise = off;
          else if (rise2 < 0) rise2 = off;
        end
        if (act && rise2 < 0) hi++;
        prev = act;
        if (done[0] === 1'b1) begin
          done_off = off; cnt_at = pulse_cnt[NW-1:0];
          check($sformatf("v%0d_idle_level", v), step_out[0], vecs[v].inv);
          check($sformatf("v%0d_dir", v), dir_out[0], vecs[v].dir);
          break;
        end
        if (busy[0] !== 1'b1) busy_bad++;
      end
      check($sformatf("v%0d_first_rise", v), rise, vecs[v].exp_rise);
      check($sformatf("v%0d_high_len", v), hi, vecs[v].exp_high);
      check($sformatf("v%0d_edge_gap", v), rise2 - rise, vecs[v].exp_gap);
      check($sformatf("v%0d_done_time", v), done_off, vecs[v].exp_done);
      check($sformatf("v%0d_pulse_cnt", v), cnt_at, vecs[v].exp_cnt);
      check($sformatf("v%0d_busy_gaps", v), busy_bad, 0);
      @(negedge clk);
    end

    // Continuous mode, stop in the 2nd HIGH cycle of pulse 3.
    load(0, 6, 3, 0, 1'b0, 1'b1); start[0] = 1'b1;
    watch(0, 18, -1, done_off, cnt_at, act_cycles);
    check("cont_stop_done", done_off, 23);
    check("cont_stop_cnt", cnt_at, 3);
    check("cont_stop_active", act_cycles, 9);
    @(negedge clk);

    // Stop during SETUP.
    load(0, 4, 2, 0, 1'b0, 1'b0); start[0] = 1'b1;
    watch(0, 2, -1, done_off, cnt_at, act_cycles);
    check("setup_stop_done", done_off, 3);
    check("setup_stop_cnt", cnt_at, 0);
    check("setup_stop_steps", act_cycles, 0);
    @(negedge clk);

    // Start while busy is ignored.
    load(0, 4, 2, 3, 1'b1, 1'b1); start[0] = 1'b1;
    watch(0, -1, 8, done_off, cnt_at, act_cycles);
    check("busy_start_done", done_off, 17);
    check("busy_start_cnt", cnt_at, 3);
    @(negedge clk);

    // Start and stop together in IDLE: no move, no done.
    load(0, 4, 2, 3, 1'b0, 1'b0); start[0] = 1'b1; stop[0] = 1'b1;
    bad = 0;
    for (int off = 1; off <= 10; off++) begin
      @(negedge clk);
      start[0] = 1'b0; stop[0] = 1'b0;
      if (busy[0] !== 1'b0 || done[0] !== 1'b0) bad++;
    end
    check("start_stop_idle", bad, 0);

    // Independent channels started on the same cycle.
    load(0, 6, 2, 5, 1'b0, 1'b0); load(1, 9, 4, 2, 1'b1, 1'b1); start = 2'b11;
    d0 = -1; d1 = -1;
    for (int off = 1; off <= 100 && (d0 < 0 || d1 < 0); off++) begin
      @(negedge clk);
      start = 2'b00;
      if (done[0] === 1'b1 && d0 < 0) d0 = off;
      if (done[1] === 1'b1 && d1 < 0) d1 = off;
    end
    check("indep_ch0_done", d0, 35);
    check("indep_ch1_done", d1, 23);
    @(negedge clk);

    // Reset in the middle of HIGH (active-low step, so active level is 0).
    load(0, 10, 5, 3, 1'b1, 1'b1); start[0] = 1'b1;
    repeat (6) begin @(negedge clk); start[0] = 1'b0; end
    check("rst_pre_busy", busy[0], 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_high", {step_out[0], busy[0], done[0], dir_out[0]}, 4'b0000);
    bad = 0;
    for (int off = 0; off < 60; off++) begin
      @(negedge clk);
      if (done !== 2'b00 || busy !== 2'b00) bad++;
    end
    check("rst_no_done", bad, 0);

    // Random stimulus against the reference model.
    rst = 1'b1; start = '0; stop = '0;
    @(negedge clk);
    rst = 1'b0;
    for (int ch = 0; ch < CH; ch++) begin m_has[ch] = 1'b0; m_inv[ch] = 1'b0; m_dir[ch] = 1'b0; end
    for (longint c = 0; c < 4000; c++) begin
      for (int ch = 0; ch < CH; ch++)
        check($sformatf("rand_ch%0d_c%0d", ch, c),
              {step_out[ch], dir_out[ch], busy[ch], done[ch], pulse_cnt[ch*NW +: NW]}, model_out(ch, c));
      rst = ($urandom_range(0, 499) == 0);
      for (int ch = 0; ch < CH; ch++) begin
        load(ch, int'($urandom_range(0, 9)), int'($urandom_range(0, 10)), int'($urandom_range(0, 5)),
             1'($urandom), 1'($urandom));
        start[ch] = ($urandom_range(0, 3) == 0);
        stop[ch]  = ($urandom_range(0, 24) == 0);
      end
      for (int ch = 0; ch < CH; ch++) begin
        if (rst) begin
          m_has[ch] = 1'b0; m_inv[ch] = 1'b0; m_dir[ch] = 1'b0;
        end else if (!(m_has[ch] && c < m_tdone[ch])) begin
          if (start[ch] && !stop[ch]) begin
            longint per, hl, num;
            per = period[ch*CW +: CW]; hl = high_len[ch*CW +: CW]; num = pulse_num[ch*NW +: NW];
            m_has[ch] = 1'b1; m_t0[ch] = c;
            m_p[ch] = (per < 2) ? 2 : per;
            m_h[ch] = (hl < 1) ? 1 : hl;
            if (m_h[ch] > m_p[ch] - 1) m_h[ch] = m_p[ch] - 1;
            m_nend[ch]  = (num == 0) ? -1 : num;
            m_tdone[ch] = (num == 0) ? NEVER : c + 1 + DS + num * m_p[ch];
            m_inv[ch] = invert[ch]; m_dir[ch] = dir_in[ch];
          end
        end else if (stop[ch]) begin
          longint o, k;
          o = c - m_t0[ch] - 1;
          if (o < DS) begin
            m_nend[ch] = 0; m_tdone[ch] = c + 1;
          end else begin
            k = (o - DS) / m_p[ch];
            if (m_nend[ch] < 0 || k + 1 < m_nend[ch]) m_nend[ch] = k + 1;
            m_tdone[ch] = m_t0[ch] + 1 + DS + m_nend[ch] * m_p[ch];
          end
        end
      end
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/step_pulse_gen_mc.md
# step_pulse_gen_mc

Multi-channel step/direction pulse generator for the stepper driver path. Each channel emits a programmable number of step pulses (or a continuous train), with programmable period, high time, polarity and direction. A direction-setup delay precedes the first step. Each channel has a start/stop/busy/done handshake, so the motion controller above can sequence moves without polling counters.

## Interface
Parameters:
- CHANNELS, 2: number of independent step/dir channels.
- CNT_W, 16: width of the period and high-time counters.
- NUM_W, 32: width of the pulse-number and pulse-count fields.
- DIR_SETUP, 4: cycles between a `dir_out` update and the first step edge (minimum 1).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- start  in  CHANNELS  per-channel start request; sampled in IDLE only.
- stop  in  CHANNELS  per-channel stop request.
- dir_in  in  CHANNELS  requested direction, latched at start.
- invert  in  CHANNELS  step polarity (1 = active-low step), latched at start.
- period  in  CHANNELS*CNT_W  step period in clk cycles, channel i at [i*CNT_W +: CNT_W].
- high_len  in  CHANNELS*CNT_W  step active time in cycles.
- pulse_num  in  CHANNELS*NUM_W  pulses per move; 0 = continuous.
- step_out  out  CHANNELS  registered step output.
- dir_out  out  CHANNELS  registered direction output.
- busy  out  CHANNELS  channel executing a move.
- done  out  CHANNELS  one-cycle strobe at move end.
- pulse_cnt  out  CHANNELS*NUM_W  completed pulses in the current or last move.

## Operation
Per-channel state machine: IDLE, SETUP, HIGH, LOW.
- **IDLE.** `start`=1 and `stop`=0 latch period, high_len, pulse_num, dir_in and invert. Then clear `pulse_cnt`, load `dir_out`, and go to SETUP.
- **SETUP.** Lasts DIR_SETUP cycles, then HIGH.
- **HIGH.** Step is active for H cycles, then LOW.
- **LOW.** Step is inactive for P−H cycles. At the end of LOW, `pulse_cnt` increments.
  - If pulse_num≠0 and the new count equals pulse_num, go to IDLE with `done`.
  - Otherwise go to HIGH.

Clamping of latched values:
- P = max(period, 2).
- H = min(max(high_len, 1), P−1).

Output and handshake rules:
- `step_out` = active XOR latched invert, so idle level = latched invert.
- `start` while busy is ignored. Inputs change freely mid-move; only values latched at start apply.
- `stop` in SETUP: return to IDLE next cycle, `done`=1, `pulse_cnt`=0, no step emitted.
- `stop` in HIGH/LOW: the current pulse completes in full and is counted. Then return to IDLE with `done`.
- `start` and `stop` together in IDLE: stop wins; remain IDLE, no `done`.
- Continuous mode: `pulse_cnt` wraps 2^NUM_W−1→0; the move ends only on `stop`.
- `rst` mid-move: next cycle all channels IDLE, no `done` emitted.
- Reset values: step_out=0, dir_out=0, busy=0, done=0, pulse_cnt=0, latched invert=0.
- Channels are fully independent; no shared counters.

## Timing
- `start` sampled at cycle t:
  - `busy`=1 and `dir_out` valid from t+1.
  - First step active edge at t+1+DIR_SETUP.
- Step active exactly H cycles; active edges exactly P cycles apart.
- `pulse_cnt` updates on the cycle after the last LOW cycle of each pulse.
- On the final pulse, the cycle after its last LOW cycle has `busy`=0 and `done`=1.
- A new `start` is accepted in that same cycle; the next move's first step comes DIR_SETUP+1 cycles later.
- Move length for N pulses: 1+DIR_SETUP+N·P cycles from start sample to `done`.

## Structure
- Package `step_pulse_pkg` holds:
  - state encodings (ST_IDLE, ST_SETUP, ST_HIGH, ST_LOW);
  - the minimum-period constant (2);
  - clamp functions for P and H.
- Sub-module `step_pulse_chan` implements one channel: FSM, phase counter, pulse counter and output registers.
- The top generates CHANNELS instances and slices the flat buses.

## Test plan
- Single move, CH0: P=10, H=3, N=4, invert=0, DIR_SETUP=4 → 4 pulses of 3 high/7 low; first rise at t+5; `done` at t+45; `pulse_cnt`=4.
- Clamping: period=1, high_len=0 → P=2, H=1 (50% duty). period=5, high_len=9 → H=4.
- Stop: continuous mode (N=0), `stop` asserted in the 2nd cycle of HIGH of pulse 3 → pulse 3 completes; `done`; `pulse_cnt`=3. `stop` during SETUP → no step, `done`, count 0.
- Polarity/handshake:
  - invert=1 → idle high, active-low pulses.
  - `start` while busy → ignored.
  - `start` and `stop` together in IDLE → no move.
- Independence: CH0 P=6 N=5, CH1 P=9 N=2 started on the same cycle → correct per-channel `done` times.
- Reset: `rst` mid-HIGH → step_out=0, busy=0 next cycle, no `done`.
